// File: rtl/seq_gen_ab.sv
// seq_gen_ab: emits a burst of a-then-b symbol pairs to a downstream detector.
// Each pair is followed by a programmable idle gap. The detector's acknowledge
// is checked during every b cycle, and a sticky error is raised when it is missing.
// All outputs are registered and decoded from the FSM state (Moore style).
module seq_gen_ab #(
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [GAP_W-1:0] gap,
   input  logic             y_in,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] sent
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EMIT_A = 3'd1,
      ST_EMIT_B = 3'd2,
      ST_GAP    = 3'd3,
      ST_FIN    = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt_lat;
   logic [GAP_W-1:0] r_gap_lat;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [CNT_W-1:0] r_sent;
   logic             r_err;
   logic             r_a;
   logic             r_b;
   logic             r_busy;
   logic             r_done;
   logic             w_accept;
   logic             w_gap_end;

   // A start request only counts while idle; start during a burst is dropped.
   assign w_accept  = (r_state == ST_IDLE) && start;
   // The gap counter is loaded with the latched gap, so gap+1 GAP cycles elapse.
   assign w_gap_end = (r_gap_cnt == {GAP_W{1'b0}});

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (count != {CNT_W{1'b0}}) begin
                  w_state_nxt = ST_EMIT_A;
               end else begin
                  w_state_nxt = ST_FIN;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_EMIT_A: w_state_nxt = ST_EMIT_B;
         ST_EMIT_B: w_state_nxt = ST_GAP;
         ST_GAP: begin
            if (w_gap_end) begin
               if (r_sent == r_cnt_lat) begin
                  w_state_nxt = ST_FIN;
               end else begin
                  w_state_nxt = ST_EMIT_A;
               end
            end else begin
               w_state_nxt = ST_GAP;
            end
         end
         ST_FIN:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Burst datapath: latch parameters on accept, count pairs, track gap, flag missing ack.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt_lat <= {CNT_W{1'b0}};
         r_gap_lat <= {GAP_W{1'b0}};
         r_gap_cnt <= {GAP_W{1'b0}};
         r_sent    <= {CNT_W{1'b0}};
         r_err     <= 1'b0;
      end else if (w_accept) begin
         r_cnt_lat <= count;
         r_gap_lat <= gap;
         r_sent    <= {CNT_W{1'b0}};
         r_err     <= 1'b0;
      end else if (r_state == ST_EMIT_B) begin
         // sent cannot pass the latched count, which fits in CNT_W, so no wrap.
         r_sent    <= r_sent + CNT_W'(1);
         r_gap_cnt <= r_gap_lat;
         if (!y_in) begin
            r_err <= 1'b1;
         end
      end else if ((r_state == ST_GAP) && !w_gap_end) begin
         r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
   end

   // Output registers decoded from the next state, so they track the state register exactly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a    <= 1'b0;
         r_b    <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_a    <= (w_state_nxt == ST_EMIT_A);
         r_b    <= (w_state_nxt == ST_EMIT_B);
         r_busy <= (w_state_nxt != ST_IDLE);
         r_done <= (w_state_nxt == ST_FIN);
      end
   end

   assign a    = r_a;
   assign b    = r_b;
   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;
   assign sent = r_sent;

endmodule

// File: tb/tb_seq_gen_ab.sv
// tb_seq_gen_ab: randomized bursts against a timeline model of seq_gen_ab.
// The driver queues one expected burst per accepted start; the monitor
// compares every cycle against that burst's timeline and retires it on done.
module tb_seq_gen_ab;
   localparam int CNT_W = 4;
   localparam int GAP_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] count = '0;
   logic [GAP_W-1:0] gap = '0;
   logic             y_in;
   logic             a, b, busy, done, err;
   logic [CNT_W-1:0] sent;

   seq_gen_ab #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .count(count), .gap(gap),
      .y_in(y_in), .a(a), .b(b), .busy(busy), .done(done), .err(err), .sent(sent)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream a-then-b detector: pulses y when b follows a directly.
   logic seen_a = 1'b0;
   logic ack_en = 1'b1;
   logic y_noise = 1'b0;
   logic y_det;
   always @(posedge clk) seen_a <= a;
   assign y_det = seen_a & b;
   // Noise is only injected outside b cycles, where the design must ignore it.
   assign y_in  = (ack_en & y_det) | (y_noise & ~b);

   typedef struct {
      int s;
      int n;
      int g;
      bit ack;
   } item_t;

   item_t q[$];
   int checks = 0;
   int errors = 0;
   int last_sent = 0;
   int last_err = 0;
   bit mon_en = 1'b0;
   int ypulses = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Monitor: expected outputs from the burst timeline (period 3+gap, a at 1+k*period).
   item_t m_it;
   int m_c, m_p, m_dc, ea, eb, ebusy, edone, eerr, esent;
   always @(negedge clk) begin
      if (mon_en) begin
         if (q.size() == 0) begin
            ea = 0; eb = 0; ebusy = 0; edone = 0;
            esent = last_sent; eerr = last_err;
            ypulses = 0;
            m_c = 0; m_dc = -1;
         end else begin
            m_it = q[0];
            m_c  = cyc - m_it.s;
            m_p  = 3 + m_it.g;
            m_dc = (m_it.n == 0) ? 1 : 1 + m_it.n * m_p;
            ea    = (m_c >= 1 && m_c < m_dc && ((m_c - 1) % m_p) == 0) ? 1 : 0;
            eb    = (m_c >= 2 && m_c < m_dc && ((m_c - 2) % m_p) == 0) ? 1 : 0;
            ebusy = (m_c >= 1 && m_c <= m_dc) ? 1 : 0;
            edone = (m_c == m_dc) ? 1 : 0;
            if (m_c < 1) begin
               esent = last_sent;
               eerr  = last_err;
            end else begin
               esent = (m_c < 3) ? 0 : ((m_c - 3) / m_p + 1);
               if (esent > m_it.n) esent = m_it.n;
               eerr = (!m_it.ack && m_it.n > 0 && m_c >= 3) ? 1 : 0;
            end
            if (m_c >= 1 && y_det === 1'b1) ypulses++;
         end
         chk("a", int'(a), ea);
         chk("b", int'(b), eb);
         chk("busy", int'(busy), ebusy);
         chk("done", int'(done), edone);
         chk("err", int'(err), eerr);
         chk("sent", int'(sent), esent);
         if (q.size() != 0 && m_c == m_dc) begin
            chk("y_pulses", ypulses, m_it.n);
            last_sent = m_it.n;
            last_err  = (!m_it.ack && m_it.n > 0) ? 1 : 0;
            ypulses   = 0;
            void'(q.pop_front());
         end
      end
   end

   // Issue one start and wait for the burst to retire; optional mid-burst noise/reset.
   task automatic run_burst(input int n, input int g, input bit ack, input bit noisy, input int rst_off);
      int t;
      @(posedge clk); #1;
      ack_en = ack;
      start  = 1'b1;
      count  = CNT_W'(n);
      gap    = GAP_W'(g);
      q.push_back('{s: cyc, n: n, g: g, ack: ack});
      t = 0;
      forever begin
         @(posedge clk); #1;
         t++;
         if (rst_off > 0 && t == rst_off + 1) begin
            q.delete();
            last_sent = 0;
            last_err  = 0;
            rst_n = 1'b1;
            start = 1'b0;
            break;
         end
         if (q.size() == 0 && rst_n) begin
            start = 1'b0;
            break;
         end
         if (t > 300) begin
            errors++;
            $display("FAIL burst_timeout cycle=%0d got busy=%0d expected done within 300 cycles", cyc, busy);
            q.delete();
            start = 1'b0;
            break;
         end
         y_noise = 1'($urandom_range(0, 1));
         if (noisy) begin
            start = 1'($urandom_range(0, 1));
            count = CNT_W'($urandom);
            gap   = GAP_W'($urandom);
         end else begin
            start = 1'b0;
         end
         if (rst_off > 0 && t == rst_off) rst_n = 1'b0;
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog cycle=%0d got no finish expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_burst(1, 0, 1'b1, 1'b0, 0);   // single pair
      run_burst(3, 2, 1'b1, 1'b0, 0);   // multi pair
      run_burst(0, 5, 1'b1, 1'b0, 0);   // zero count
      run_burst(2, 3, 1'b0, 1'b0, 0);   // missing ack
      run_burst(1, 1, 1'b1, 1'b0, 0);   // err clears on next start
      run_burst(4, 1, 1'b1, 1'b1, 0);   // start re-pulsed, count/gap changed mid-burst
      run_burst(15, 7, 1'b1, 1'b0, 0);  // full count, no wrap
      run_burst(3, 2, 1'b1, 1'b0, 9);   // reset in GAP of pair 2
      run_burst(2, 0, 1'b1, 1'b0, 0);   // normal burst after reset
      for (int i = 0; i < 30; i++) begin
         run_burst($urandom_range(0, 15), $urandom_range(0, 7),
                   ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 30) : 0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
